// File: rtl/a2rt_frame_ctrl_pkg.sv
// a2rt_pkg: shared types and defaults for the a2rt frame front end.
//   frame_state_t : frame sequencer states
//   pixel_t       : default-width pixel word
//   A2RT_*        : default pixel width and screen geometry
package a2rt_pkg;

    localparam int A2RT_DATA_WIDTH    = 24;
    localparam int A2RT_SCREEN_WIDTH  = 800;
    localparam int A2RT_SCREEN_HEIGHT = 600;

    typedef logic [A2RT_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2,
        WAIT_CORE = 2'd3
    } frame_state_t;

endpackage

// File: rtl/a2rt_frame_ctrl_if.sv
// a2rt_axis_if: AXI-stream pixel link (valid/ready/data/last).
//   master : drives tvalid, tdata, tlast; receives tready
//   slave  : receives tvalid, tdata, tlast; drives tready
interface a2rt_axis_if
    import a2rt_pkg::*;
#(
    parameter int DATA_WIDTH = A2RT_DATA_WIDTH
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/a2rt_frame_ctrl_xy_counter.sv
// a2rt_xy_counter: raster x/y position counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr_i       : return to (0,0); wins over en_i
//   en_i        : advance one pixel
//   x_o, y_o    : current column / line
//   last_pix_o  : current position is the final pixel of the frame
module a2rt_xy_counter
    import a2rt_pkg::*;
#(
    parameter int SCREEN_WIDTH  = A2RT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = A2RT_SCREEN_HEIGHT,
    parameter int XW            = $clog2(SCREEN_WIDTH),
    parameter int YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_pix_o
);
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          x_end;
    logic          y_end;

    assign x_end      = (x_q == XW'(SCREEN_WIDTH - 1));
    assign y_end      = (y_q == YW'(SCREEN_HEIGHT - 1));
    assign last_pix_o = x_end & y_end;
    assign x_o        = x_q;
    assign y_o        = y_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            if (x_end) begin
                x_q <= '0;
                // the line counter also wraps so a reused counter never leaves the raster
                y_q <= y_end ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/a2rt_frame_ctrl.sv
// a2rt_frame_ctrl: admits one raster frame per start command from an
// AXI-stream source and forwards it to the a2rt core with sow/eow and x/y
// tags, policing tlast against the pixel count.
//   clk, rst_n            : clock, synchronous active-low reset
//   start_i, continuous_i : arm one frame / re-arm automatically
//   abort_i               : cancel the current frame
//   s_axis (slave)        : pixel source
//   rts_o, rtr_i          : beat valid / ready towards the core
//   sow_o, eow_o          : first / last beat markers (qualified by rts_o)
//   pixel_o, x_o, y_o     : pixel and its coordinates
//   core_eow_i            : core finished its output window
//   busy_o, frame_done_o, frame_cnt_o : status
//   err_early_last_o, err_late_last_o : sticky tlast errors
module a2rt_frame_ctrl
    import a2rt_pkg::*;
#(
    parameter int DATA_WIDTH    = A2RT_DATA_WIDTH,
    parameter int SCREEN_WIDTH  = A2RT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = A2RT_SCREEN_HEIGHT,
    parameter int XW            = $clog2(SCREEN_WIDTH),
    parameter int YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  abort_i,
    a2rt_axis_if.slave            s_axis,
    output logic                  rts_o,
    input  logic                  rtr_i,
    output logic                  sow_o,
    output logic                  eow_o,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic [XW-1:0]         x_o,
    output logic [YW-1:0]         y_o,
    input  logic                  core_eow_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  err_early_last_o,
    output logic                  err_late_last_o
);
    frame_state_t state;
    logic         core_eow_pend;
    logic         in_run;
    logic         in_flush;
    logic         beat;
    logic         last_pix;
    logic         flush_done;
    logic         core_done;
    logic         enter_run;
    logic         cnt_clr;

    assign in_run   = (state == RUN);
    assign in_flush = (state == FLUSH);

    // Zero-latency datapath: the source beat is the core beat
    assign rts_o         = in_run & s_axis.tvalid;
    assign s_axis.tready = in_flush | (in_run & rtr_i);
    assign beat          = rts_o & rtr_i;
    assign pixel_o       = s_axis.tdata;

    assign sow_o  = in_run & (x_o == '0) & (y_o == '0);
    // a short frame's eow is the beat carrying the premature tlast
    assign eow_o  = in_run & (last_pix | s_axis.tlast);
    assign busy_o = (state != IDLE);

    assign flush_done = in_flush & s_axis.tvalid & s_axis.tlast;
    // a core_eow seen earlier in the frame counts as soon as we get here
    assign core_done  = (state == WAIT_CORE) & (core_eow_i | core_eow_pend);
    assign enter_run  = ((state == IDLE) & start_i) | (core_done & continuous_i);
    assign cnt_clr    = abort_i | enter_run;

    a2rt_xy_counter #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .XW            (XW),
        .YW            (YW)
    ) u_xy (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .en_i       (beat),
        .x_o        (x_o),
        .y_o        (y_o),
        .last_pix_o (last_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            core_eow_pend    <= 1'b0;
            frame_done_o     <= 1'b0;
            frame_cnt_o      <= '0;
            err_early_last_o <= 1'b0;
            err_late_last_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (abort_i) begin
                state         <= IDLE;
                core_eow_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state            <= RUN;
                            core_eow_pend    <= 1'b0;
                            err_early_last_o <= 1'b0;
                            err_late_last_o  <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (core_eow_i) core_eow_pend <= 1'b1;
                        if (beat) begin
                            if (s_axis.tlast) begin
                                state <= WAIT_CORE;
                                if (!last_pix) err_early_last_o <= 1'b1;
                            end else if (last_pix) begin
                                state           <= FLUSH;
                                err_late_last_o <= 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        if (core_eow_i) core_eow_pend <= 1'b1;
                        if (flush_done) state <= WAIT_CORE;
                    end
                    WAIT_CORE: begin
                        if (core_done) begin
                            frame_done_o  <= 1'b1;
                            frame_cnt_o   <= frame_cnt_o + 16'd1;
                            core_eow_pend <= 1'b0;
                            state         <= continuous_i ? RUN : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_a2rt_frame_ctrl.sv
// tb_a2rt_frame_ctrl: directed self-checking bench for a2rt_frame_ctrl
// on an 8x2 raster (16 pixels per frame).
module tb_a2rt_frame_ctrl;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int DW = 24;

    logic          tb_clk = 1'b0;
    logic          tb_reset_n;
    logic          start_i, continuous_i, abort_i, rtr_i, core_eow_i;
    logic          rts_o, sow_o, eow_o, busy_o, frame_done_o;
    logic          err_early_last_o, err_late_last_o;
    logic [DW-1:0] pixel_o;
    logic [2:0]    x_o;
    logic [0:0]    y_o;
    logic [15:0]   frame_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 tb_clk = ~tb_clk;

    a2rt_axis_if #(.DATA_WIDTH(DW)) s_axis ();

    a2rt_frame_ctrl #(
        .DATA_WIDTH    (DW),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H)
    ) dut (
        .clk              (tb_clk),
        .rst_n            (tb_reset_n),
        .start_i          (start_i),
        .continuous_i     (continuous_i),
        .abort_i          (abort_i),
        .s_axis           (s_axis),
        .rts_o            (rts_o),
        .rtr_i            (rtr_i),
        .sow_o            (sow_o),
        .eow_o            (eow_o),
        .pixel_o          (pixel_o),
        .x_o              (x_o),
        .y_o              (y_o),
        .core_eow_i       (core_eow_i),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .frame_cnt_o      (frame_cnt_o),
        .err_early_last_o (err_early_last_o),
        .err_late_last_o  (err_late_last_o)
    );

    // inputs change on the falling edge, outputs are sampled there too
    task automatic tick();
        @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    function automatic logic [DW-1:0] pix(input int f, input int n);
        return 24'(32'hC00000 + f * 256 + n);
    endfunction

    // offers one source beat and waits (bounded) for it to be accepted
    task automatic send_beat(input logic [DW-1:0] d, input logic last, output logic ok,
                             output logic [2:0] ox, output logic [0:0] oy,
                             output logic osow, output logic oeow, output logic orts,
                             output logic [DW-1:0] opix);
        ok = 1'b0; ox = '0; oy = '0; osow = 1'b0; oeow = 1'b0; orts = 1'b0; opix = '0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tlast  = last;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (s_axis.tready === 1'b1) begin
                ok = 1'b1; ox = x_o; oy = y_o; osow = sow_o; oeow = eow_o;
                orts = rts_o; opix = pixel_o;
            end
            tick();
            if (ok) break;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        tb_reset_n = 1'b0;
        s_axis.tvalid = 1'b1;
        rtr_i = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (rts_o !== 1'b0 || s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_hs rts=%b tready=%b want 0/0", rts_o, s_axis.tready); end
        checks++; if (sow_o !== 1'b0 || eow_o !== 1'b0) begin errors++; $display("FAIL reset_marks sow=%b eow=%b want 0/0", sow_o, eow_o); end
        checks++; if (frame_cnt_o !== 16'd0 || frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_cnt cnt=%0d done=%b want 0/0", frame_cnt_o, frame_done_o); end
        checks++; if (err_early_last_o !== 1'b0 || err_late_last_o !== 1'b0) begin errors++; $display("FAIL reset_err early=%b late=%b want 0/0", err_early_last_o, err_late_last_o); end
        checks++; if (x_o !== 3'd0 || y_o !== 1'd0) begin errors++; $display("FAIL reset_xy x=%0d y=%0d want 0/0", x_o, y_o); end
        s_axis.tvalid = 1'b0;
        tb_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic ok, bsow, beow, brts;
        logic [2:0] bx;
        logic [0:0] by;
        logic [DW-1:0] bpix;
        start_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nom_idle_busy got %b want 0", busy_o); end
        tick();
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL nom_run_busy got %b want 1", busy_o); end
        for (int i = 0; i < 16; i++) begin
            send_beat(pix(1, i), (i == 15), ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nom_beat%0d_accept got %b want 1", i + 1, ok); end
            checks++; if (bsow !== (i == 0) || beow !== (i == 15) || brts !== 1'b1) begin errors++; $display("FAIL nom_beat%0d_marks sow=%b eow=%b rts=%b", i + 1, bsow, beow, brts); end
            checks++; if (bx !== 3'(i % 8) || by !== 1'(i / 8)) begin errors++; $display("FAIL nom_beat%0d_xy got %0d,%0d want %0d,%0d", i + 1, bx, by, i % 8, i / 8); end
            checks++; if (bpix !== pix(1, i)) begin errors++; $display("FAIL nom_beat%0d_pix got %h want %h", i + 1, bpix, pix(1, i)); end
        end
        checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin errors++; $display("FAIL nom_wait busy=%b done=%b want 1/0", busy_o, frame_done_o); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL nom_no_early_done got %b want 0", frame_done_o); end
        core_eow_i = 1'b1;
        tick();
        core_eow_i = 1'b0;
        checks++; if (frame_done_o !== 1'b1) begin errors++; $display("FAIL nom_done got %b want 1", frame_done_o); end
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL nom_cnt got %0d want 1", frame_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nom_back_idle busy got %b want 0", busy_o); end
        checks++; if (err_early_last_o !== 1'b0 || err_late_last_o !== 1'b0) begin errors++; $display("FAIL nom_err early=%b late=%b want 0/0", err_early_last_o, err_late_last_o); end
        tick();
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL nom_done_pulse got %b want 0", frame_done_o); end
    endtask

    task automatic test_backpressure();
        logic [3:0] bp;
        int beats;
        bp = 4'b1001;
        beats = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 100 && beats < 16; c++) begin
            rtr_i = bp[c % 4];
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = pix(2, beats);
            s_axis.tlast  = (beats == 15);
            #1;
            checks++; if (s_axis.tready !== rtr_i || rts_o !== 1'b1) begin errors++; $display("FAIL bp_c%0d_hs tready=%b rts=%b want %b/1", c, s_axis.tready, rts_o, rtr_i); end
            if (rtr_i) begin
                checks++; if (x_o !== 3'(beats % 8) || y_o !== 1'(beats / 8)) begin errors++; $display("FAIL bp_beat%0d_xy got %0d,%0d want %0d,%0d", beats + 1, x_o, y_o, beats % 8, beats / 8); end
                checks++; if (pixel_o !== pix(2, beats)) begin errors++; $display("FAIL bp_beat%0d_pix got %h want %h", beats + 1, pixel_o, pix(2, beats)); end
                beats++;
            end
            tick();
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        rtr_i = 1'b1;
        checks++; if (beats != 16) begin errors++; $display("FAIL bp_beats got %0d want 16", beats); end
        core_eow_i = 1'b1;
        tick();
        core_eow_i = 1'b0;
        checks++; if (frame_done_o !== 1'b1 || frame_cnt_o !== 16'd2) begin errors++; $display("FAIL bp_done done=%b cnt=%0d want 1/2", frame_done_o, frame_cnt_o); end
    endtask

    task automatic test_early_last();
        logic ok, bsow, beow, brts;
        logic [2:0] bx;
        logic [0:0] by;
        logic [DW-1:0] bpix;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_beat(pix(3, i), (i == 9), ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1 || beow !== (i == 9)) begin errors++; $display("FAIL early_beat%0d ok=%b eow=%b want 1/%b", i + 1, ok, beow, (i == 9)); end
            if (i == 9) begin
                checks++; if (bx !== 3'd1 || by !== 1'd1) begin errors++; $display("FAIL early_last_xy got %0d,%0d want 1,1", bx, by); end
            end
        end
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = pix(3, 10);
        #1;
        checks++; if (err_early_last_o !== 1'b1 || err_late_last_o !== 1'b0) begin errors++; $display("FAIL early_err early=%b late=%b want 1/0", err_early_last_o, err_late_last_o); end
        checks++; if (s_axis.tready !== 1'b0 || rts_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL early_wait tready=%b rts=%b busy=%b want 0/0/1", s_axis.tready, rts_o, busy_o); end
        tick();
        tick();
        s_axis.tvalid = 1'b0;
        core_eow_i = 1'b1;
        tick();
        core_eow_i = 1'b0;
        checks++; if (frame_done_o !== 1'b1 || frame_cnt_o !== 16'd3 || busy_o !== 1'b0) begin errors++; $display("FAIL early_done done=%b cnt=%0d busy=%b want 1/3/0", frame_done_o, frame_cnt_o, busy_o); end
        checks++; if (err_early_last_o !== 1'b1) begin errors++; $display("FAIL early_sticky got %b want 1", err_early_last_o); end
    endtask

    task automatic test_late_last();
        logic ok, bsow, beow, brts;
        logic [2:0] bx;
        logic [0:0] by;
        logic [DW-1:0] bpix;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (err_early_last_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL late_start_clr early=%b busy=%b want 0/1", err_early_last_o, busy_o); end
        for (int i = 0; i < 16; i++) begin
            send_beat(pix(4, i), 1'b0, ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1 || beow !== (i == 15) || bsow !== (i == 0)) begin errors++; $display("FAIL late_beat%0d ok=%b sow=%b eow=%b", i + 1, ok, bsow, beow); end
        end
        checks++; if (err_late_last_o !== 1'b1 || err_early_last_o !== 1'b0) begin errors++; $display("FAIL late_err late=%b early=%b want 1/0", err_late_last_o, err_early_last_o); end
        for (int i = 16; i < 19; i++) begin
            send_beat(pix(4, i), (i == 18), ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1 || brts !== 1'b0 || beow !== 1'b0) begin errors++; $display("FAIL late_flush%0d ok=%b rts=%b eow=%b want 1/0/0", i + 1, ok, brts, beow); end
            if (i == 16) begin
                // core finishes while the source is still being drained
                core_eow_i = 1'b1;
                tick();
                core_eow_i = 1'b0;
                checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin errors++; $display("FAIL late_flush_hold busy=%b done=%b want 1/0", busy_o, frame_done_o); end
            end
        end
        checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0 || s_axis.tready !== 1'b0) begin errors++; $display("FAIL late_wait busy=%b done=%b tready=%b want 1/0/0", busy_o, frame_done_o, s_axis.tready); end
        tick();
        checks++; if (frame_done_o !== 1'b1 || frame_cnt_o !== 16'd4 || busy_o !== 1'b0) begin errors++; $display("FAIL late_done done=%b cnt=%0d busy=%b want 1/4/0", frame_done_o, frame_cnt_o, busy_o); end
    endtask

    task automatic test_continuous();
        logic ok, bsow, beow, brts;
        logic [2:0] bx;
        logic [0:0] by;
        logic [DW-1:0] bpix;
        continuous_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                send_beat(pix(5 + f, i), (i == 15), ok, bx, by, bsow, beow, brts, bpix);
                checks++; if (ok !== 1'b1 || bsow !== (i == 0) || beow !== (i == 15)) begin errors++; $display("FAIL cont_f%0d_beat%0d ok=%b sow=%b eow=%b", f, i + 1, ok, bsow, beow); end
            end
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = pix(5 + f + 1, 0);
            #1;
            checks++; if (s_axis.tready !== 1'b0 || rts_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL cont_f%0d_hold tready=%b rts=%b busy=%b want 0/0/1", f, s_axis.tready, rts_o, busy_o); end
            tick();
            tick();
            s_axis.tvalid = 1'b0;
            core_eow_i = 1'b1;
            tick();
            core_eow_i = 1'b0;
            checks++; if (frame_done_o !== 1'b1 || frame_cnt_o !== 16'(5 + f)) begin errors++; $display("FAIL cont_f%0d_done done=%b cnt=%0d want 1/%0d", f, frame_done_o, frame_cnt_o, 5 + f); end
            checks++; if (busy_o !== 1'b1 || x_o !== 3'd0 || y_o !== 1'd0) begin errors++; $display("FAIL cont_f%0d_rearm busy=%b x=%0d y=%0d want 1/0/0", f, busy_o, x_o, y_o); end
        end
        continuous_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || frame_cnt_o !== 16'd7 || frame_done_o !== 1'b0) begin errors++; $display("FAIL cont_abort busy=%b cnt=%0d done=%b want 0/7/0", busy_o, frame_cnt_o, frame_done_o); end
    endtask

    task automatic test_abort();
        logic ok, bsow, beow, brts;
        logic [2:0] bx;
        logic [0:0] by;
        logic [DW-1:0] bpix;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_beat(pix(9, i), 1'b0, ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1 || bx !== 3'(i)) begin errors++; $display("FAIL abort_pre%0d ok=%b x=%0d want 1/%0d", i + 1, ok, bx, i); end
        end
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = pix(9, 6);
        abort_i = 1'b1;
        start_i = 1'b1;
        #1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        s_axis.tvalid = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || rts_o !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b rts=%b want 0/0", busy_o, rts_o); end
        checks++; if (x_o !== 3'd0 || y_o !== 1'd0) begin errors++; $display("FAIL abort_xy got %0d,%0d want 0,0", x_o, y_o); end
        checks++; if (frame_cnt_o !== 16'd7 || frame_done_o !== 1'b0) begin errors++; $display("FAIL abort_cnt cnt=%0d done=%b want 7/0", frame_cnt_o, frame_done_o); end
        tick();
        checks++; if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_after done=%b busy=%b want 0/0", frame_done_o, busy_o); end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_beat(pix(10, i), (i == 15), ok, bx, by, bsow, beow, brts, bpix);
            checks++; if (ok !== 1'b1 || bsow !== (i == 0) || bx !== 3'(i % 8) || by !== 1'(i / 8)) begin errors++; $display("FAIL restart_beat%0d ok=%b sow=%b x=%0d y=%0d", i + 1, ok, bsow, bx, by); end
        end
        core_eow_i = 1'b1;
        tick();
        core_eow_i = 1'b0;
        checks++; if (frame_done_o !== 1'b1 || frame_cnt_o !== 16'd8) begin errors++; $display("FAIL restart_done done=%b cnt=%0d want 1/8", frame_done_o, frame_cnt_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_reset_n    = 1'b0;
        start_i       = 1'b0;
        continuous_i  = 1'b0;
        abort_i       = 1'b0;
        rtr_i         = 1'b1;
        core_eow_i    = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        @(negedge tb_clk);
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_late_last();
        test_continuous();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
